// File: rtl/dp_issue_ctrl.sv
// Operand collection, credit-throttled issue and result FIFO for the 4-lane dot-product pipe.
// Optional performance counters (issue/stall) are enabled by defining DP_ISSUE_PERF_EN.
module dp_issue_ctrl #(
   parameter int unsigned PIPE_LAT   = 3,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned CNT_W      = 16
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_in_valid,
   output logic              o_in_ready,
   input  logic [31:0]       i_in_data,
   input  logic              i_in_op,
   output logic              o_pipe_op,
   output logic [31:0]       o_pipe_x0,
   output logic [31:0]       o_pipe_x1,
   output logic [31:0]       o_pipe_x2,
   output logic [31:0]       o_pipe_x3,
   output logic [31:0]       o_pipe_y0,
   output logic [31:0]       o_pipe_y1,
   output logic [31:0]       o_pipe_y2,
   output logic [31:0]       o_pipe_y3,
   input  logic [31:0]       i_pipe_z,
   output logic              o_res_valid,
   input  logic              i_res_ready,
   output logic [31:0]       o_res_data,
   output logic              o_res_op
`ifdef DP_ISSUE_PERF_EN
   ,
   output logic [CNT_W-1:0]  o_issue_cnt,
   output logic [CNT_W-1:0]  o_stall_cnt
`endif
);

   localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CW = $clog2(FIFO_DEPTH + PIPE_LAT + 1);

   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || PIPE_LAT < 1 || CNT_W < 1)
   begin : g_param_check
      $error("dp_issue_ctrl: unsupported parameter set");
   end

   typedef enum logic [0:0] {StCollect = 1'b0, StIssue = 1'b1} state_e;

   state_e              r_state;
   state_e              w_state_nxt;
   logic [2:0]          r_cnt;
   logic [31:0]         r_opnd [8];
   logic                r_op;
   logic                w_hs;
   logic                w_issue;
   logic                w_credit;

   logic [PIPE_LAT-1:0] r_sr;
   logic [PIPE_LAT-1:0] r_sr_op;
   logic [CW-1:0]       w_inflight;
   logic [CW-1:0]       w_occ;

   logic [31:0]         r_mem_data [FIFO_DEPTH];
   logic                r_mem_op   [FIFO_DEPTH];
   logic [AW-1:0]       r_wr_ptr;
   logic [AW-1:0]       r_rd_ptr;
   logic [AW:0]         r_count;
   logic                w_push;
   logic                w_pop;
   logic                w_empty;

   assign w_hs = i_in_valid && o_in_ready;

   always_comb begin
      w_inflight = '0;
      for (int i = 0; i < int'(PIPE_LAT); i++) begin
         w_inflight = w_inflight + CW'(r_sr[i]);
      end
   end

   // Registered occupancy only: a pop in this cycle does not lend credit until next cycle.
   assign w_occ    = CW'(r_count) + w_inflight;
   assign w_credit = (w_occ < CW'(FIFO_DEPTH));

   always_comb begin
      w_state_nxt = r_state;
      w_issue     = 1'b0;
      o_in_ready  = 1'b0;
      unique case (r_state)
         StCollect: begin
            o_in_ready = 1'b1;
            if (i_in_valid && (r_cnt == 3'd7)) begin
               w_state_nxt = StIssue;
            end
         end
         StIssue: begin
            if (w_credit) begin
               w_issue     = 1'b1;
               w_state_nxt = StCollect;
            end
         end
         default: w_state_nxt = StCollect;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= StCollect;
         r_cnt   <= 3'd0;
         r_op    <= 1'b0;
         for (int i = 0; i < 8; i++) begin
            r_opnd[i] <= '0;
         end
      end else begin
         r_state <= w_state_nxt;
         if (w_hs) begin
            r_opnd[r_cnt] <= i_in_data;
            r_cnt         <= r_cnt + 3'd1;
            if (r_cnt == 3'd0) begin
               r_op <= i_in_op;
            end
         end
      end
   end

   assign o_pipe_op = r_op;
   assign o_pipe_x0 = r_opnd[0];
   assign o_pipe_x1 = r_opnd[1];
   assign o_pipe_x2 = r_opnd[2];
   assign o_pipe_x3 = r_opnd[3];
   assign o_pipe_y0 = r_opnd[4];
   assign o_pipe_y1 = r_opnd[5];
   assign o_pipe_y2 = r_opnd[6];
   assign o_pipe_y3 = r_opnd[7];

   // Issue tags walk alongside the pipe stages; the top bit marks a valid pipe_z this cycle.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sr    <= '0;
         r_sr_op <= '0;
      end else begin
         r_sr[0]    <= w_issue;
         r_sr_op[0] <= r_op;
         for (int i = 1; i < int'(PIPE_LAT); i++) begin
            r_sr[i]    <= r_sr[i-1];
            r_sr_op[i] <= r_sr_op[i-1];
         end
      end
   end

   assign w_push  = r_sr[PIPE_LAT-1];
   assign w_empty = (r_count == '0);
   assign w_pop   = i_res_ready && !w_empty;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
            r_mem_data[i] <= '0;
            r_mem_op[i]   <= 1'b0;
         end
      end else begin
         if (w_push) begin
            r_mem_data[r_wr_ptr] <= i_pipe_z;
            r_mem_op[r_wr_ptr]   <= r_sr_op[PIPE_LAT-1];
            r_wr_ptr             <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + (AW+1)'(1);
         end else if (!w_push && w_pop) begin
            r_count <= r_count - (AW+1)'(1);
         end
      end
   end

   assign o_res_valid = !w_empty;
   assign o_res_data  = w_empty ? 32'd0 : r_mem_data[r_rd_ptr];
   assign o_res_op    = w_empty ? 1'b0 : r_mem_op[r_rd_ptr];

`ifdef DP_ISSUE_PERF_EN
   logic             w_stall;
   logic [CNT_W-1:0] r_issue_cnt;
   logic [CNT_W-1:0] r_stall_cnt;

   assign w_stall = (r_state == StIssue) && !w_credit;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_issue_cnt <= '0;
         r_stall_cnt <= '0;
      end else begin
         if (w_issue && (r_issue_cnt != '1)) begin
            r_issue_cnt <= r_issue_cnt + CNT_W'(1);
         end
         if (w_stall && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         end
      end
   end

   assign o_issue_cnt = r_issue_cnt;
   assign o_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_dp_issue_ctrl.sv
// Directed bench for dp_issue_ctrl; a 3-stage integer-sum stand-in plays the pipe,
// so z = x0+x1+x2+x3+y0+y1+y2+y3 (mod 2^32) three edges after the operands are presented.
module tb_dp_issue_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_data = '0;
   logic        in_op = 1'b0;
   logic        pipe_op;
   logic [31:0] px0, px1, px2, px3, py0, py1, py2, py3;
   logic [31:0] pipe_z;
   logic        res_valid;
   logic        res_ready = 1'b0;
   logic [31:0] res_data;
   logic        res_op;
`ifdef DP_ISSUE_PERF_EN
   logic [15:0] issue_cnt;
   logic [15:0] stall_cnt;
`endif

   int n_total = 0;
   int n_bad   = 0;

   always #5 clk = ~clk;

   dp_issue_ctrl u_dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_in_valid  (in_valid),
      .o_in_ready  (in_ready),
      .i_in_data   (in_data),
      .i_in_op     (in_op),
      .o_pipe_op   (pipe_op),
      .o_pipe_x0   (px0),
      .o_pipe_x1   (px1),
      .o_pipe_x2   (px2),
      .o_pipe_x3   (px3),
      .o_pipe_y0   (py0),
      .o_pipe_y1   (py1),
      .o_pipe_y2   (py2),
      .o_pipe_y3   (py3),
      .i_pipe_z    (pipe_z),
      .o_res_valid (res_valid),
      .i_res_ready (res_ready),
      .o_res_data  (res_data),
      .o_res_op    (res_op)
`ifdef DP_ISSUE_PERF_EN
      ,
      .o_issue_cnt (issue_cnt),
      .o_stall_cnt (stall_cnt)
`endif
   );

   // Pipe stand-in: three register stages, combinational last stage is a pass-through.
   logic [31:0] pz1, pz2, pz3;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pz1 <= '0;
         pz2 <= '0;
         pz3 <= '0;
      end else begin
         pz1 <= px0 + px1 + px2 + px3 + py0 + py1 + py2 + py3;
         pz2 <= pz1;
         pz3 <= pz2;
      end
   end
   assign pipe_z = pz3;

   // Issues are seen as in_ready returning high; pops as valid&ready at an edge.
   int   n_issue = 0;
   int   n_pop   = 0;
   int   max_occ = 0;
   logic prev_rdy = 1'b1;
   always_ff @(posedge clk) begin
      prev_rdy <= in_ready;
      if (in_ready && !prev_rdy) n_issue <= n_issue + 1;
      if (res_valid && res_ready) n_pop <= n_pop + 1;
      if (n_issue - n_pop > max_occ) max_occ <= n_issue - n_pop;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   task automatic send_word(input logic [31:0] d, input logic op);
      int n = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_op    = op;
      while (in_ready !== 1'b1 && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (n >= 400) check("in_ready_timeout", 32'd0, 32'd1);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // Returns at the negedge of the cycle after word 7 was accepted.
   task automatic send_vec(input logic [31:0] w [8], input logic op0, input logic opr,
                           input bit gap);
      for (int i = 0; i < 8; i++) begin
         send_word(w[i], (i == 0) ? op0 : opr);
         if (gap && i == 3) begin
            repeat (3) @(negedge clk);
            check("gap_in_ready", 32'(in_ready), 32'd1);
         end
      end
   endtask

   task automatic wait_lat(output int lat);
      int n = 1;
      while (res_valid !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      lat = n;
   endtask

   task automatic pop_check(input string tag, input logic [31:0] d, input logic op);
      check({tag, "_valid"}, 32'(res_valid), 32'd1);
      check({tag, "_data"}, res_data, d);
      check({tag, "_op"}, 32'(res_op), 32'(op));
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
   endtask

   logic [31:0] v_a [8];
   logic [31:0] v_b [8];
   logic [31:0] v_c [8];
   logic [31:0] v_k [8];
   logic [31:0] res_q [6];

   initial begin
      int lat;
      int base_issue;
      int got;
      int n;
      v_a = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000,
              32'h40000000, 32'h40000000, 32'h40000000, 32'h40000000};
      v_b = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd10, 32'd20, 32'd30, 32'd40};
      v_c = '{32'h100, 32'h200, 32'h300, 32'h400, 32'd0, 32'd0, 32'd0, 32'd5};

      // Reset values
      repeat (3) @(negedge clk);
      check("rst_res_valid", 32'(res_valid), 32'd0);
      check("rst_res_data", res_data, 32'd0);
      check("rst_res_op", 32'(res_op), 32'd0);
      check("rst_pipe_op", 32'(pipe_op), 32'd0);
      check("rst_pipe_x0", px0, 32'd0);
      check("rst_pipe_y3", py3, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_in_ready", 32'(in_ready), 32'd1);

      // Basic: latency 5 from word 7 acceptance
      res_ready = 1'b1;
      send_vec(v_a, 1'b1, 1'b1, 1'b0);
      wait_lat(lat);
      check("basic_lat", 32'(lat), 32'd5);
      check("basic_data", res_data, 32'hFE000000);
      check("basic_op", 32'(res_op), 32'd1);
      @(negedge clk);
      check("basic_empty", 32'(res_valid), 32'd0);

      // Valid gap between words 3 and 4
      send_vec(v_b, 1'b1, 1'b1, 1'b1);
      check("gap_x0", px0, 32'd1);
      check("gap_x3", px3, 32'd4);
      check("gap_y0", py0, 32'd10);
      check("gap_y3", py3, 32'd40);
      wait_lat(lat);
      check("gap_lat", 32'(lat), 32'd5);
      check("gap_data", res_data, 32'h6E);
      check("gap_op", 32'(res_op), 32'd1);
      repeat (10) @(negedge clk);
      check("gap_no_extra", 32'(res_valid), 32'd0);
      res_ready = 1'b0;

      // Mode latch: op sampled only on word 0
      send_vec(v_b, 1'b0, 1'b1, 1'b0);
      check("mode_issue_op", 32'(pipe_op), 32'd0);
      send_vec(v_c, 1'b1, 1'b0, 1'b0);
      check("mode_b_op", 32'(pipe_op), 32'd1);
      repeat (6) @(negedge clk);
      pop_check("mode_r0", 32'h6E, 1'b0);
      pop_check("mode_r1", 32'hA05, 1'b1);
      check("mode_empty", 32'(res_valid), 32'd0);

      // Simultaneous push and pop with one entry held
      send_vec(v_b, 1'b0, 1'b0, 1'b0);
      wait_lat(lat);
      check("pp_first_lat", 32'(lat), 32'd5);
      send_vec(v_c, 1'b1, 1'b1, 1'b0);
      repeat (3) @(negedge clk);
      check("pp_head_before", res_data, 32'h6E);
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      check("pp_valid", 32'(res_valid), 32'd1);
      check("pp_head_after", res_data, 32'hA05);
      @(negedge clk);
      check("pp_hold", res_data, 32'hA05);
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      check("pp_count_one", 32'(res_valid), 32'd0);

      // Backpressure: 6 vectors into a 4-entry FIFO with no consumer
      base_issue = n_issue;
`ifdef DP_ISSUE_PERF_EN
      begin : perf_base
         int base_ic = int'(issue_cnt);
`endif
      for (int k = 0; k < 5; k++) begin
         v_k = '{32'h11 + 32'(k), 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
         send_vec(v_k, 1'b0, 1'b0, 1'b0);
      end
      repeat (20) @(negedge clk);
      check("bp_stalled", 32'(in_ready), 32'd0);
      check("bp_issues4", 32'(n_issue - base_issue), 32'd4);
      check("bp_head", res_data, 32'h11);
      got = 0;
      fork
         begin
            logic [31:0] v6 [8];
            v6 = '{32'h16, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
            send_vec(v6, 1'b0, 1'b0, 1'b0);
         end
         begin
            n = 0;
            res_ready = 1'b1;
            while (got < 6 && n < 400) begin
               if (res_valid === 1'b1) begin
                  res_q[got] = res_data;
                  got++;
               end
               @(negedge clk);
               n++;
            end
            res_ready = 1'b0;
         end
      join
      check("bp_count", 32'(got), 32'd6);
      for (int k = 0; k < 6; k++) begin
         if (k < got) check("bp_order", res_q[k], 32'h11 + 32'(k));
      end
      repeat (2) @(negedge clk);
      check("bp_issues6", 32'(n_issue - base_issue), 32'd6);
      check("bp_no_overflow", 32'(max_occ <= 4), 32'd1);
`ifdef DP_ISSUE_PERF_EN
         check("perf_issue", 32'(int'(issue_cnt) - base_ic), 32'd6);
         check("perf_stall", 32'(stall_cnt > 0), 32'd1);
      end
`endif

      // Reset two cycles after issue discards the in-flight result
      send_vec(v_b, 1'b1, 1'b1, 1'b0);
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check("mrst_valid", 32'(res_valid), 32'd0);
      check("mrst_in_ready", 32'(in_ready), 32'd1);
      check("mrst_x0", px0, 32'd0);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      check("mrst_no_push", 32'(res_valid), 32'd0);
      res_ready = 1'b1;
      send_vec(v_c, 1'b1, 1'b1, 1'b0);
      wait_lat(lat);
      check("mrst_lat", 32'(lat), 32'd5);
      check("mrst_data", res_data, 32'hA05);
      check("mrst_op", 32'(res_op), 32'd1);
      res_ready = 1'b0;

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

endmodule
